// File: rtl/dm_responder.sv
// dm_responder: single-port 16-bit word memory responder with a fixed
// request-to-completion latency. A request is accepted in IDLE and committed
// LATENCY cycles later, with a one-cycle rdy pulse. Out-of-range accesses
// complete normally but raise err. Simultaneous re/we is rejected with err.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        rdy,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               accept;
    logic               complete;
    logic               conflict;
    logic               addr_oor;

    // Request captured at acceptance; BUSY-time input changes never reach these.
    logic [ADDR_W-1:0]  addr_q;
    logic               op_write_q;
    logic               oor_q;
    logic [15:0]        data_q;

    logic [15:0]        mem [0:(1<<ADDR_W)-1];

    // Any set bit above the implemented width marks the address as out of range.
    generate
        if (ADDR_W < 16) begin : g_oor
            assign addr_oor = |addr[15:ADDR_W];
        end else begin : g_no_oor
            assign addr_oor = 1'b0;
        end
    endgenerate

    assign busy = (state == BUSY);

    // State and latency counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: accept exactly one of re/we in IDLE, count down in BUSY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        conflict   = 1'b0;
        case (state)
            IDLE: begin
                if (re ^ we) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = BUSY;
                end else if (re && we) begin
                    conflict = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, read-data register and the rdy/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            op_write_q <= 1'b0;
            oor_q      <= 1'b0;
            data_q     <= 16'h0000;
            rd_data    <= 16'h0000;
            rdy        <= 1'b0;
            err        <= 1'b0;
        end else begin
            rdy <= complete;
            err <= conflict | (complete & oor_q);
            if (accept) begin
                addr_q     <= addr[ADDR_W-1:0];
                op_write_q <= we;
                oor_q      <= addr_oor;
                data_q     <= wrt_data;
            end
            if (complete && !op_write_q) begin
                rd_data <= oor_q ? 16'h0000 : mem[addr_q];
            end
        end
    end

    // Memory write port; out-of-range writes are dropped, never aliased.
    always_ff @(posedge clk) begin
        if (complete && op_write_q && !oor_q) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder (LATENCY=3, ADDR_W=10).
module tb_dm_responder;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        busy;
    logic        rdy;
    logic        err;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [15:0] rd_model;

    dm_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wrt_data (wrt_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .rdy      (rdy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: accept, LAT-1 busy cycles, then the completion cycle.
    // b2b: issue immediately (caller is in a rdy cycle). toggle: wiggle inputs while busy.
    task automatic do_op(input string tag, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic exp_err, input logic b2b, input logic toggle);
        if (!b2b) @(negedge clk);
        re = r; we = w; addr = a; wrt_data = d;
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        chk({tag, "_acc_busy"}, 16'(busy), 16'd1);
        for (int i = 1; i < LAT; i++) begin
            if (toggle) begin
                re = ~re; addr = addr ^ 16'h00FF; wrt_data = ~wrt_data;
            end
            @(posedge clk); #1;
            chk({tag, "_wait_busy"}, 16'(busy), 16'd1);
            chk({tag, "_wait_rdy"}, 16'(rdy), 16'd0);
        end
        if (toggle) begin
            re = 1'b1; addr = 16'h0010;
        end
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        chk({tag, "_rdy"}, 16'(rdy), 16'd1);
        chk({tag, "_busy_lo"}, 16'(busy), 16'd0);
        chk({tag, "_err"}, 16'(err), 16'(exp_err));
        chk({tag, "_rd_data"}, rd_data, rd_model);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = 16'h0000; wrt_data = 16'h0000;
        rd_model = 16'h0000;
        @(posedge clk); #1;
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rdy", 16'(rdy), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back.
        do_op("wr5", 1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        rd_model = 16'hBEEF;
        do_op("rd5", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back: the read is issued inside the write's rdy cycle.
        do_op("wr10", 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0);
        rd_model = 16'h1234;
        do_op("rd10_b2b", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Conflict: re and we together are rejected.
        @(negedge clk);
        re = 1'b1; we = 1'b1; addr = 16'h0005; wrt_data = 16'hDEAD;
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        chk("conf_err", 16'(err), 16'd1);
        chk("conf_busy", 16'(busy), 16'd0);
        chk("conf_rdy", 16'(rdy), 16'd0);
        chk("conf_rd_data", rd_data, rd_model);
        @(posedge clk); #1;
        chk("conf_err_lo", 16'(err), 16'd0);
        rd_model = 16'hBEEF;
        do_op("conf_rd5", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Out-of-range accesses; address 0 must not be aliased by 0x400.
        do_op("wr0", 1'b0, 1'b1, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        do_op("oor_wr", 1'b0, 1'b1, 16'h0400, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        rd_model = 16'h0000;
        do_op("oor_rd", 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b0, 1'b0);
        rd_model = 16'h0F0F;
        do_op("rd0", 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a write aborts it.
        do_op("wr3", 1'b0, 1'b1, 16'h0003, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        we = 1'b1; addr = 16'h0003; wrt_data = 16'h5555;
        @(posedge clk); #1;
        we = 1'b0;
        chk("mid_acc_busy", 16'(busy), 16'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_rdy", 16'(rdy), 16'd0);
        chk("mid_rst_rd_data", rd_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_rdy", 16'(rdy), 16'd0);
            chk("post_rst_busy", 16'(busy), 16'd0);
        end
        rd_model = 16'h1111;
        do_op("rd3_after_rst", 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Inputs toggling while busy are ignored.
        rd_model = 16'hBEEF;
        do_op("rd5_toggle", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("idle_after_toggle", 16'(busy), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
